safe_bus_arbiter_nmr: RTL and testbench

Parametrised redundancy bus stage between an N-hart CPU cluster and the system OBI fabric; one instance per channel (instruction or data).
- Routes each hart's OBI port in one of four run-time modes: independent, single-bus, dual-lockstep compare, triple-modular majority vote.
- Drains outstanding transactions before any mode change.
- Counts outstanding transactions per port and reports redundancy mismatches with a saturating error counter and a sticky fatal flag.

---
 rtl/safe_bus_arbiter_nmr.sv | 274 +++++++++++++++++++++++++++
 tb/tb_safe_bus_arbiter_nmr.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/safe_bus_arbiter_nmr.sv
// -----------------------------------------------------------------------------
// safe_bus_arbiter_nmr
// Redundancy bus stage between an N-hart CPU cluster and the OBI fabric.
// One instance serves one channel (instruction or data). It routes hart ports
// in one of four run-time modes. INDEP passes every port straight through.
// SINGLE forwards only the master hart. DMR is SINGLE plus a lockstep compare
// against the next hart. TMR forwards a bitwise majority vote of harts 0..2.
// Outstanding transactions are drained before any mode change. Redundancy
// disagreements are reported through a pulse, a saturating counter and a
// sticky fatal flag.
//
// Ports
//   clk_i, rst_i    clock, synchronous active-high reset
//   core_req_i      hart-side OBI requests          [NHARTS]
//   core_resp_o     hart-side OBI responses         [NHARTS]
//   bus_req_o       fabric-side OBI requests        [NHARTS]
//   bus_resp_i      fabric-side OBI responses       [NHARTS]
//   mode_i          requested mode (0 INDEP, 1 SINGLE, 2 DMR, 3 TMR)
//   master_i        requested master hart
//   mode_req_i      single-cycle mode-change request
//   mode_ack_o      one-cycle pulse when the new mode is applied
//   mode_o          current mode
//   master_o        current master hart
//   mismatch_o      one-cycle pulse per detected disagreement
//   err_cnt_o       saturating mismatch count
//   fatal_o         sticky uncorrectable (DMR) mismatch
//   err_clr_i       clears err_cnt_o and fatal_o
// -----------------------------------------------------------------------------
package safe_bus_arbiter_nmr_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module safe_bus_arbiter_nmr
  import safe_bus_arbiter_nmr_pkg::*;
#(
  parameter int         NHARTS          = 3,
  parameter int         MAX_OUTSTANDING = 4,
  parameter int         ERR_CNT_W       = 8,
  parameter logic [1:0] RESET_MODE      = 2'd0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  obi_req_t                    core_req_i  [NHARTS],
  output obi_resp_t                   core_resp_o [NHARTS],
  output obi_req_t                    bus_req_o   [NHARTS],
  input  obi_resp_t                   bus_resp_i  [NHARTS],
  input  logic [1:0]                  mode_i,
  input  logic [$clog2(NHARTS)-1:0]   master_i,
  input  logic                        mode_req_i,
  output logic                        mode_ack_o,
  output logic [1:0]                  mode_o,
  output logic [$clog2(NHARTS)-1:0]   master_o,
  output logic                        mismatch_o,
  output logic [ERR_CNT_W-1:0]        err_cnt_o,
  output logic                        fatal_o,
  input  logic                        err_clr_i
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int MW = $clog2(NHARTS);
  localparam int RW = $bits(obi_req_t);
  // Third voter index; folds onto hart 0 when there is no third hart so the
  // expression stays in range (TMR is demoted to DMR in that case anyway).
  localparam int H2 = (NHARTS > 2) ? 2 : 0;
  localparam logic [CW-1:0]        MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    MODE_INDEP  = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_DMR    = 2'd2,
    MODE_TMR    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } state_e;

  state_e         state_q;
  mode_e          mode_q, pendMode_q, effMode;
  logic [MW-1:0]  master_q, pendMaster_q, shadow;
  logic           modeAck_q;
  logic [CW-1:0]  outCnt_q [NHARTS];
  logic [CW-1:0]  outCnt_d [NHARTS];
  logic           allIdleNext;
  logic           running;
  logic [NHARTS-1:0] portOpen;
  obi_req_t       voted;
  logic [RW-1:0]  v0, v1, v2;
  logic           mismatchNow;
  logic           mismatch_q;
  logic [ERR_CNT_W-1:0] errCnt_q;
  logic           fatal_q;

  function automatic logic reqDiffers(input obi_req_t a, input obi_req_t b);
    logic d;
    d = (a.req != b.req);
    if (a.req && b.req)
      d = (a.we != b.we) || (a.be != b.be) || (a.addr != b.addr) || (a.wdata != b.wdata);
    return d;
  endfunction

  // Mode actually applied to the datapath: with fewer than three harts there
  // is nothing to vote over, so TMR falls back to a DMR compare.
  always_comb begin
    effMode = mode_q;
    if (mode_q == MODE_TMR && NHARTS < 3) effMode = MODE_DMR;
  end

  // The DMR shadow is the hart after the master, wrapping around.
  always_comb begin
    shadow = (int'(master_q) == NHARTS - 1) ? '0 : master_q + MW'(1);
  end

  // Bitwise majority over every request field of harts 0..2.
  always_comb begin
    v0 = core_req_i[0];
    v1 = core_req_i[1];
    v2 = core_req_i[H2];
    voted = obi_req_t'((v0 & v1) | (v0 & v2) | (v1 & v2));
  end

  // A port may accept a new request only while the FSM is running and it has
  // a free slot. A response retiring in this same cycle frees its slot, so a
  // full port can still take a new request alongside an rvalid.
  always_comb begin
    running = (state_q == ST_RUN);
    for (int i = 0; i < NHARTS; i++)
      portOpen[i] = running && ((outCnt_q[i] != MAX_CNT) || bus_resp_i[i].rvalid);
  end

  // Request/response routing. Responses always follow the current mode_q,
  // so a drain still delivers the old mode's responses. Grants seen by a hart
  // come from the fabric port that hart is routed to and are gated by the
  // same openness as that port's request.
  always_comb begin
    for (int i = 0; i < NHARTS; i++) begin
      bus_req_o[i]   = '0;
      core_resp_o[i] = bus_resp_i[i];
    end
    case (effMode)
      MODE_INDEP: begin
        for (int i = 0; i < NHARTS; i++) bus_req_o[i] = core_req_i[i];
      end
      MODE_TMR: begin
        bus_req_o[master_q] = voted;
        for (int i = 0; i < NHARTS; i++) core_resp_o[i] = bus_resp_i[master_q];
      end
      default: begin
        bus_req_o[master_q] = core_req_i[master_q];
        for (int i = 0; i < NHARTS; i++) core_resp_o[i] = bus_resp_i[master_q];
      end
    endcase
    for (int i = 0; i < NHARTS; i++) begin
      if (!portOpen[i]) bus_req_o[i].req = 1'b0;
      if (effMode == MODE_INDEP)
        core_resp_o[i].gnt = core_resp_o[i].gnt & portOpen[i];
      else
        core_resp_o[i].gnt = core_resp_o[i].gnt & portOpen[master_q];
    end
  end

  // Outstanding-transaction bookkeeping per fabric port. An accept and a
  // retire in the same cycle cancel; a stray rvalid at zero is ignored.
  always_comb begin
    allIdleNext = 1'b1;
    for (int i = 0; i < NHARTS; i++) begin
      outCnt_d[i] = outCnt_q[i];
      if (bus_req_o[i].req && bus_resp_i[i].gnt) begin
        if (!bus_resp_i[i].rvalid) outCnt_d[i] = outCnt_q[i] + CW'(1);
      end else if (bus_resp_i[i].rvalid && outCnt_q[i] != '0) begin
        outCnt_d[i] = outCnt_q[i] - CW'(1);
      end
      if (outCnt_d[i] != '0) allIdleNext = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NHARTS; i++) begin
      if (rst_i) outCnt_q[i] <= '0;
      else       outCnt_q[i] <= outCnt_d[i];
    end
  end

  // Redundancy comparison, only while running in DMR or TMR.
  always_comb begin
    mismatchNow = 1'b0;
    if (running) begin
      case (effMode)
        MODE_DMR: mismatchNow = reqDiffers(core_req_i[master_q], core_req_i[shadow]);
        MODE_TMR: mismatchNow = reqDiffers(core_req_i[0], core_req_i[1]) ||
                                reqDiffers(core_req_i[0], core_req_i[H2]) ||
                                reqDiffers(core_req_i[1], core_req_i[H2]);
        default:  mismatchNow = 1'b0;
      endcase
    end
  end

  // Mode FSM. The drain ends on the edge where every counter's next value is
  // zero, so the switch happens the cycle after the last response retires.
  // An out-of-range master request is folded to hart 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      mode_q       <= mode_e'(RESET_MODE);
      master_q     <= '0;
      pendMode_q   <= mode_e'(RESET_MODE);
      pendMaster_q <= '0;
      modeAck_q    <= 1'b0;
    end else begin
      modeAck_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (mode_req_i) begin
            pendMode_q   <= mode_e'(mode_i);
            pendMaster_q <= (int'(master_i) < NHARTS) ? master_i : '0;
            state_q      <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (allIdleNext) begin
            mode_q    <= pendMode_q;
            master_q  <= pendMaster_q;
            modeAck_q <= 1'b1;
            state_q   <= ST_SWITCH;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Error reporting. A clear wins over a same-cycle increment or fatal set,
  // but the mismatch pulse itself is never suppressed. Only DMR is fatal,
  // since TMR corrects the disagreement by voting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mismatch_q <= 1'b0;
      errCnt_q   <= '0;
      fatal_q    <= 1'b0;
    end else begin
      mismatch_q <= mismatchNow;
      if (err_clr_i) begin
        errCnt_q <= '0;
        fatal_q  <= 1'b0;
      end else if (mismatchNow) begin
        if (errCnt_q != ERR_MAX) errCnt_q <= errCnt_q + ERR_CNT_W'(1);
        if (effMode == MODE_DMR) fatal_q <= 1'b1;
      end
    end
  end

  assign mode_ack_o = modeAck_q;
  assign mode_o     = mode_q;
  assign master_o   = master_q;
  assign mismatch_o = mismatch_q;
  assign err_cnt_o  = errCnt_q;
  assign fatal_o    = fatal_q;

endmodule

// File: tb/tb_safe_bus_arbiter_nmr.sv
// -----------------------------------------------------------------------------
// tb_safe_bus_arbiter_nmr
// Directed bench for safe_bus_arbiter_nmr with NHARTS=3, MAX_OUTSTANDING=4,
// ERR_CNT_W=2. Inputs change 1 time unit after a rising edge; combinational
// outputs are sampled 1 unit later and registered outputs 1 unit after the
// edge that loads them.
// -----------------------------------------------------------------------------
module tb_safe_bus_arbiter_nmr;
  import safe_bus_arbiter_nmr_pkg::*;

  localparam int NH = 3;

  logic      clk = 1'b0;
  logic      rst;
  obi_req_t  coreReq  [NH];
  obi_resp_t coreResp [NH];
  obi_req_t  busReq   [NH];
  obi_resp_t busResp  [NH];
  logic [1:0] modeIn;
  logic [1:0] masterIn;
  logic      modeReq;
  logic      modeAck;
  logic [1:0] modeOut;
  logic [1:0] masterOut;
  logic      mismatch;
  logic [1:0] errCnt;
  logic      fatal;
  logic      errClr;

  int testsRun    = 0;
  int testsFailed = 0;

  safe_bus_arbiter_nmr #(
    .NHARTS(NH), .MAX_OUTSTANDING(4), .ERR_CNT_W(2), .RESET_MODE(2'd0)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(coreReq), .core_resp_o(coreResp),
    .bus_req_o(busReq), .bus_resp_i(busResp),
    .mode_i(modeIn), .master_i(masterIn), .mode_req_i(modeReq),
    .mode_ack_o(modeAck), .mode_o(modeOut), .master_o(masterOut),
    .mismatch_o(mismatch), .err_cnt_o(errCnt), .fatal_o(fatal),
    .err_clr_i(errClr)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  function automatic obi_req_t mkReq(input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata);
    obi_req_t r;
    r.req = 1'b1; r.we = we; r.be = 4'hF; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Return every input to idle.
  task automatic applyStimulus();
    for (int i = 0; i < NH; i++) begin
      coreReq[i] = '0;
      busResp[i] = '0;
    end
    modeIn = 2'd0; masterIn = 2'd0; modeReq = 1'b0; errClr = 1'b0;
  endtask

  // Mode change with idle ports: request, drain, switch, back to run.
  task automatic doSwitch(input logic [1:0] m, input logic [1:0] ms);
    applyStimulus();
    modeReq = 1'b1; modeIn = m; masterIn = ms;
    tick();
    modeReq = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus();
    tick(); tick();
    testsRun++; if (modeOut !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_mode: got %0d expected 0", modeOut); end
    testsRun++; if (masterOut !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_master: got %0d expected 0", masterOut); end
    testsRun++; if ({modeAck, mismatch, errCnt, fatal} !== 5'b0) begin testsFailed++; $display("[TB] FAIL reset_flags: got %b expected 00000", {modeAck, mismatch, errCnt, fatal}); end
    rst = 1'b0;
  endtask

  task automatic test_indep();
    applyStimulus();
    for (int i = 0; i < NH; i++) begin
      coreReq[i] = mkReq(1'b0, 32'h100 * (i + 1), 32'h0);
      busResp[i].gnt = 1'b1;
    end
    #1;
    for (int i = 0; i < NH; i++) begin
      testsRun++; if (busReq[i].addr !== 32'h100 * (i + 1) || busReq[i].req !== 1'b1) begin testsFailed++; $display("[TB] FAIL indep_bus_req%0d: got addr %0h req %b expected addr %0h req 1", i, busReq[i].addr, busReq[i].req, 32'h100 * (i + 1)); end
    end
    tick();
    applyStimulus();
    for (int i = 0; i < NH; i++) begin
      busResp[i].rvalid = 1'b1;
      busResp[i].rdata  = 32'hA000_0000 + i;
    end
    #1;
    for (int i = 0; i < NH; i++) begin
      testsRun++; if (coreResp[i].rdata !== 32'hA000_0000 + i || coreResp[i].rvalid !== 1'b1) begin testsFailed++; $display("[TB] FAIL indep_rdata%0d: got %0h expected %0h", i, coreResp[i].rdata, 32'hA000_0000 + i); end
    end
    tick();
    testsRun++; if (mismatch !== 1'b0) begin testsFailed++; $display("[TB] FAIL indep_no_mismatch: got %b expected 0", mismatch); end
    applyStimulus();
  endtask

  task automatic test_mode_switch();
    applyStimulus();
    coreReq[0] = mkReq(1'b0, 32'h40, 32'h0);
    busResp[0].gnt = 1'b1;
    tick(); tick();
    applyStimulus();
    modeReq = 1'b1; modeIn = 2'd2; masterIn = 2'd1;
    tick();
    modeReq = 1'b0;
    coreReq[0] = mkReq(1'b0, 32'h44, 32'h0);
    busResp[0].gnt = 1'b1;
    #1;
    testsRun++; if (busReq[0].req !== 1'b0 || coreResp[0].gnt !== 1'b0) begin testsFailed++; $display("[TB] FAIL drain_block: got req %b gnt %b expected 0 0", busReq[0].req, coreResp[0].gnt); end
    tick();
    applyStimulus();
    busResp[0].rvalid = 1'b1;
    tick();
    testsRun++; if (modeAck !== 1'b0) begin testsFailed++; $display("[TB] FAIL drain_wait_ack: got %b expected 0", modeAck); end
    tick();
    busResp[0].rvalid = 1'b0;
    testsRun++; if (modeAck !== 1'b1 || modeOut !== 2'd2 || masterOut !== 2'd1) begin testsFailed++; $display("[TB] FAIL switch_ack: got ack %b mode %0d master %0d expected 1 2 1", modeAck, modeOut, masterOut); end
    tick();
    testsRun++; if (modeAck !== 1'b0) begin testsFailed++; $display("[TB] FAIL ack_pulse: got %b expected 0", modeAck); end
    for (int i = 0; i < NH; i++) begin
      coreReq[i] = mkReq(1'b1, 32'h60, 32'h55);
      busResp[i].gnt = 1'b1;
      busResp[i].rdata = 32'hB000_0000 + i;
    end
    #1;
    testsRun++; if (busReq[1].req !== 1'b1 || busReq[0] !== '0 || busReq[2] !== '0) begin testsFailed++; $display("[TB] FAIL dmr_routing: got req1 %b bus0 %0h bus2 %0h expected 1 0 0", busReq[1].req, busReq[0], busReq[2]); end
    testsRun++; if (coreResp[0].rdata !== 32'hB000_0001) begin testsFailed++; $display("[TB] FAIL dmr_resp_route: got %0h expected b0000001", coreResp[0].rdata); end
    tick();
    applyStimulus();
    busResp[1].rvalid = 1'b1;
    testsRun++; if (mismatch !== 1'b0) begin testsFailed++; $display("[TB] FAIL dmr_equal: got %b expected 0", mismatch); end
    tick();
    applyStimulus();
  endtask

  task automatic test_dmr_mismatch();
    applyStimulus();
    modeReq = 1'b1; modeIn = 2'd2; masterIn = 2'd0;
    tick();
    modeReq = 1'b0;
    testsRun++; if (modeAck !== 1'b0 || masterOut !== 2'd1) begin testsFailed++; $display("[TB] FAIL latency_t1: got ack %b master %0d expected 0 1", modeAck, masterOut); end
    tick();
    testsRun++; if (modeAck !== 1'b1 || masterOut !== 2'd0) begin testsFailed++; $display("[TB] FAIL latency_t2: got ack %b master %0d expected 1 0", modeAck, masterOut); end
    tick();
    coreReq[0] = mkReq(1'b1, 32'h80, 32'h11);
    coreReq[1] = mkReq(1'b1, 32'h80, 32'h11);
    tick();
    testsRun++; if (mismatch !== 1'b0) begin testsFailed++; $display("[TB] FAIL dmr_agree: got %b expected 0", mismatch); end
    coreReq[1].addr = 32'h84;
    #1;
    testsRun++; if (busReq[0].addr !== 32'h80 || busReq[1] !== '0) begin testsFailed++; $display("[TB] FAIL dmr_master_fwd: got addr %0h bus1 %0h expected 80 0", busReq[0].addr, busReq[1]); end
    tick();
    coreReq[1].addr = 32'h80;
    testsRun++; if (mismatch !== 1'b1 || errCnt !== 2'd1 || fatal !== 1'b1) begin testsFailed++; $display("[TB] FAIL dmr_mismatch: got mm %b cnt %0d fatal %b expected 1 1 1", mismatch, errCnt, fatal); end
    tick();
    testsRun++; if (mismatch !== 1'b0 || errCnt !== 2'd1 || fatal !== 1'b1) begin testsFailed++; $display("[TB] FAIL dmr_sticky: got mm %b cnt %0d fatal %b expected 0 1 1", mismatch, errCnt, fatal); end
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    testsRun++; if (errCnt !== 2'd0 || fatal !== 1'b0) begin testsFailed++; $display("[TB] FAIL dmr_clear: got cnt %0d fatal %b expected 0 0", errCnt, fatal); end
    applyStimulus();
  endtask

  task automatic test_tmr();
    doSwitch(2'd3, 2'd2);
    coreReq[0] = mkReq(1'b1, 32'h200, 32'h1234_5678);
    coreReq[1] = mkReq(1'b1, 32'h200, 32'h1234_5678);
    coreReq[2] = mkReq(1'b1, 32'h200, 32'hDEAD_BEEF);
    busResp[0].rdata = 32'h0000_0AAA;
    busResp[2].rdata = 32'hCAFE_0002;
    #1;
    testsRun++; if (busReq[2].wdata !== 32'h1234_5678 || busReq[2].req !== 1'b1) begin testsFailed++; $display("[TB] FAIL tmr_vote: got %0h req %b expected 12345678 1", busReq[2].wdata, busReq[2].req); end
    testsRun++; if (busReq[0] !== '0 || coreResp[0].rdata !== 32'hCAFE_0002) begin testsFailed++; $display("[TB] FAIL tmr_routing: got bus0 %0h rdata %0h expected 0 cafe0002", busReq[0], coreResp[0].rdata); end
    tick();
    testsRun++; if (mismatch !== 1'b1 || errCnt !== 2'd1 || fatal !== 1'b0) begin testsFailed++; $display("[TB] FAIL tmr_corrected: got mm %b cnt %0d fatal %b expected 1 1 0", mismatch, errCnt, fatal); end
    applyStimulus();
    tick();
  endtask

  task automatic test_max_outstanding();
    doSwitch(2'd0, 2'd0);
    coreReq[0] = mkReq(1'b0, 32'h300, 32'h0);
    busResp[0].gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      testsRun++; if (busReq[0].req !== 1'b1) begin testsFailed++; $display("[TB] FAIL max_fill%0d: got %b expected 1", k, busReq[0].req); end
      tick();
    end
    #1;
    testsRun++; if (busReq[0].req !== 1'b0 || coreResp[0].gnt !== 1'b0) begin testsFailed++; $display("[TB] FAIL max_block: got req %b gnt %b expected 0 0", busReq[0].req, coreResp[0].gnt); end
    tick();
    busResp[0].rvalid = 1'b1;
    #1;
    testsRun++; if (busReq[0].req !== 1'b1 || coreResp[0].gnt !== 1'b1) begin testsFailed++; $display("[TB] FAIL max_refill: got req %b gnt %b expected 1 1", busReq[0].req, coreResp[0].gnt); end
    tick();
    busResp[0].rvalid = 1'b0;
    #1;
    testsRun++; if (busReq[0].req !== 1'b0) begin testsFailed++; $display("[TB] FAIL max_still_full: got %b expected 0", busReq[0].req); end
    applyStimulus();
    busResp[0].rvalid = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    applyStimulus();
    coreReq[0] = mkReq(1'b0, 32'h304, 32'h0);
    #1;
    testsRun++; if (busReq[0].req !== 1'b1) begin testsFailed++; $display("[TB] FAIL max_drained: got %b expected 1", busReq[0].req); end
    applyStimulus();
  endtask

  task automatic test_err_saturation();
    applyStimulus();
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
    doSwitch(2'd2, 2'd0);
    coreReq[1] = mkReq(1'b0, 32'h10, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      testsRun++; if (errCnt !== ((k > 3) ? 2'd3 : 2'(k))) begin testsFailed++; $display("[TB] FAIL sat_cnt%0d: got %0d expected %0d", k, errCnt, (k > 3) ? 3 : k); end
    end
    errClr = 1'b1;
    tick();
    testsRun++; if (errCnt !== 2'd0 || mismatch !== 1'b1 || fatal !== 1'b0) begin testsFailed++; $display("[TB] FAIL clr_priority: got cnt %0d mm %b fatal %b expected 0 1 0", errCnt, mismatch, fatal); end
    applyStimulus();
    tick();
    testsRun++; if (mismatch !== 1'b0 || errCnt !== 2'd0) begin testsFailed++; $display("[TB] FAIL clr_idle: got mm %b cnt %0d expected 0 0", mismatch, errCnt); end
  endtask

  task automatic test_reset_mid_drain();
    applyStimulus();
    coreReq[0] = mkReq(1'b0, 32'h500, 32'h0);
    coreReq[1] = mkReq(1'b0, 32'h500, 32'h0);
    busResp[0].gnt = 1'b1;
    tick();
    applyStimulus();
    modeReq = 1'b1; modeIn = 2'd3; masterIn = 2'd2;
    tick();
    modeReq = 1'b0;
    coreReq[0] = mkReq(1'b0, 32'h504, 32'h0);
    #1;
    testsRun++; if (busReq[0].req !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_drain_block: got %b expected 0", busReq[0].req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    testsRun++; if (modeOut !== 2'd0 || masterOut !== 2'd0 || modeAck !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_drain_reset: got mode %0d master %0d ack %b expected 0 0 0", modeOut, masterOut, modeAck); end
    applyStimulus();
    coreReq[2] = mkReq(1'b0, 32'h600, 32'h0);
    #1;
    testsRun++; if (busReq[2].req !== 1'b1) begin testsFailed++; $display("[TB] FAIL post_reset_run: got %b expected 1", busReq[2].req); end
    tick();
    testsRun++; if (modeAck !== 1'b0 || modeOut !== 2'd0) begin testsFailed++; $display("[TB] FAIL pending_discarded: got ack %b mode %0d expected 0 0", modeAck, modeOut); end
    applyStimulus();
  endtask

  // Scenario sequence; each task leaves the inputs idle for the next one.
  initial begin
    test_reset();
    test_indep();
    test_mode_switch();
    test_dmr_mismatch();
    test_tmr();
    test_max_outstanding();
    test_err_saturation();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
